// File: rtl/picomips_run_ctrl_if.sv
// Board-control / datapath bundle for the picoMIPS run/halt/step controller.
// The controller takes the slave modport; the board/datapath side takes the master.
interface picomips_run_ctrl_if #(
    parameter int PCW = 8,
    parameter int CW  = 16
);
    logic           run_req;
    logic           halt_req;
    logic           step_req;
    logic           bkpt_en;
    logic [PCW-1:0] bkpt_addr;
    logic [PCW-1:0] pc;
    logic           halt_insn;
    logic           cpu_rst;
    logic           pc_en;
    logic [1:0]     state;
    logic           halted;
    logic [2:0]     stop_cause;
    logic [CW-1:0]  cycle_count;

    modport slave (
        input  run_req, halt_req, step_req, bkpt_en, bkpt_addr, pc, halt_insn,
        output cpu_rst, pc_en, state, halted, stop_cause, cycle_count
    );

    modport master (
        output run_req, halt_req, step_req, bkpt_en, bkpt_addr, pc, halt_insn,
        input  cpu_rst, pc_en, state, halted, stop_cause, cycle_count
    );
endinterface

// File: rtl/picomips_run_ctrl.sv
// Run/halt/single-step controller for the picoMIPS core: holds the datapath in
// reset after power-up, gates pc_en, and stops on manual halt, HALT or breakpoint.
module picomips_run_ctrl #(
    parameter int PCW  = 8,
    parameter int CW   = 16,
    parameter int HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    picomips_run_ctrl_if.slave bus
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_HALT = 2'b01,
        S_RUN  = 2'b10,
        S_STEP = 2'b11
    } state_t;

    localparam logic [2:0] C_NONE   = 3'b000;
    localparam logic [2:0] C_MANUAL = 3'b001;
    localparam logic [2:0] C_HINSN  = 3'b010;
    localparam logic [2:0] C_BKPT   = 3'b011;
    localparam logic [2:0] C_STEP   = 3'b100;

    state_t        state_q, state_d;
    logic [2:0]    cause_q, cause_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] cnt_q;
    logic          first_q;
    logic          prev_run_q, prev_halt_q, prev_step_q;

    logic run_edge, halt_edge, step_edge;
    logic bkpt_hit, stop_now;
    logic pc_en;

    assign run_edge  = bus.run_req  & ~prev_run_q;
    assign halt_edge = bus.halt_req & ~prev_halt_q;
    assign step_edge = bus.step_req & ~prev_step_q;

    // first_q masks the breakpoint so a run can resume from the breakpoint address.
    assign bkpt_hit = bus.bkpt_en & (bus.pc == bus.bkpt_addr) & ~first_q;
    assign stop_now = bus.halt_insn | bkpt_hit | halt_edge;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        pc_en   = 1'b0;
        case (state_q)
            S_HOLD: begin
                if (hold_q == HW'(HOLD - 1)) begin
                    state_d = S_HALT;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_HALT: begin
                if (halt_edge) begin
                    state_d = S_HALT;
                end else if (step_edge) begin
                    state_d = S_STEP;
                    cause_d = C_NONE;
                end else if (run_edge) begin
                    state_d = S_RUN;
                    cause_d = C_NONE;
                end
            end
            S_RUN: begin
                pc_en = ~stop_now;
                if (stop_now) begin
                    state_d = S_HALT;
                    if (bus.halt_insn)  cause_d = C_HINSN;
                    else if (bkpt_hit)  cause_d = C_BKPT;
                    else                cause_d = C_MANUAL;
                end
            end
            S_STEP: begin
                pc_en   = ~bus.halt_insn;
                state_d = S_HALT;
                cause_d = bus.halt_insn ? C_HINSN : C_STEP;
            end
            default: state_d = S_HOLD;
        endcase
    end

    // Edge-detect history resets high so a button held through reset is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HOLD;
            cause_q     <= C_NONE;
            hold_q      <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            prev_run_q  <= 1'b1;
            prev_halt_q <= 1'b1;
            prev_step_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            hold_q      <= hold_d;
            first_q     <= (state_d == S_RUN) && (state_q != S_RUN);
            prev_run_q  <= bus.run_req;
            prev_halt_q <= bus.halt_req;
            prev_step_q <= bus.step_req;
            if (pc_en && (cnt_q != '1)) cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.cpu_rst     = (state_q == S_HOLD);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.state       = state_q;
    assign bus.pc_en       = pc_en;
    assign bus.stop_cause  = cause_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_picomips_run_ctrl.sv
// Directed bench for picomips_run_ctrl: a tiny PC datapath drives pc from pc_en,
// plus a second CW=4 instance for counter saturation.
module tb_picomips_run_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    always #5 clk = ~clk;

    picomips_run_ctrl_if #(.PCW(8), .CW(16)) b1 ();
    picomips_run_ctrl_if #(.PCW(8), .CW(4))  b2 ();

    picomips_run_ctrl #(.PCW(8), .CW(16), .HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    picomips_run_ctrl #(.PCW(8), .CW(4), .HOLD(4)) dut_sat (
        .clk   (clk),
        .reset (reset2),
        .bus   (b2.slave)
    );

    // Minimal datapath: PC cleared by cpu_rst, advances when pc_en is high.
    logic [7:0] pc_q;
    logic       hi_en;
    logic [7:0] hi_addr;
    always_ff @(posedge clk) begin
        if (b1.cpu_rst)    pc_q <= 8'h00;
        else if (b1.pc_en) pc_q <= pc_q + 8'h01;
    end
    assign b1.pc        = pc_q;
    assign b1.halt_insn = hi_en && (pc_q == hi_addr);

    assign b2.pc        = 8'h00;
    assign b2.halt_insn = 1'b0;
    assign b2.bkpt_en   = 1'b0;
    assign b2.bkpt_addr = 8'h00;
    assign b2.halt_req  = 1'b0;
    assign b2.step_req  = 1'b0;

    int total = 0;
    int bad   = 0;
    int n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        b1.run_req = 0; b1.halt_req = 0; b1.step_req = 0;
        b1.bkpt_en = 0; b1.bkpt_addr = 8'h00;
        b2.run_req = 0;
        hi_en = 0; hi_addr = 8'h0A;

        // Reset and HOLD sequence
        tick();
        reset = 1'b0;
        check("rst_state", 32'(b1.state), 32'h0);
        check("rst_halted", 32'(b1.halted), 32'h0);
        check("rst_pc_en", 32'(b1.pc_en), 32'h0);
        check("rst_cause", 32'(b1.stop_cause), 32'h0);
        check("rst_count", 32'(b1.cycle_count), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("hold_cpu_rst", 32'(b1.cpu_rst), 32'h1);
            tick();
        end
        check("hold_done_state", 32'(b1.state), 32'h1);
        check("hold_done_halted", 32'(b1.halted), 32'h1);
        check("hold_done_cpu_rst", 32'(b1.cpu_rst), 32'h0);
        check("hold_done_pc_en", 32'(b1.pc_en), 32'h0);

        // Run until HALT instruction at 0x0A
        hi_en = 1; hi_addr = 8'h0A;
        b1.run_req = 1;
        tick();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (b1.state == 2'b01) break;
            n += int'(b1.pc_en);
            tick();
        end
        check("hinsn_pc_en_cycles", 32'(n), 32'd10);
        check("hinsn_state", 32'(b1.state), 32'h1);
        check("hinsn_cause", 32'(b1.stop_cause), 32'h2);
        check("hinsn_count", 32'(b1.cycle_count), 32'd10);
        check("hinsn_pc", 32'(pc_q), 32'h0A);

        // Sticky HALT instruction: one RUN cycle with pc_en low
        b1.run_req = 0;
        tick();
        b1.run_req = 1;
        tick();
        check("sticky_state", 32'(b1.state), 32'h2);
        check("sticky_pc_en", 32'(b1.pc_en), 32'h0);
        tick();
        check("sticky_halt", 32'(b1.state), 32'h1);
        check("sticky_cause", 32'(b1.stop_cause), 32'h2);
        b1.run_req = 0;

        // Breakpoint at 0x05 and resume
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        hi_en = 0; b1.bkpt_en = 1; b1.bkpt_addr = 8'h05;
        b1.run_req = 1;
        tick();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (b1.state == 2'b01) break;
            n += int'(b1.pc_en);
            tick();
        end
        check("bkpt_pc_en_cycles", 32'(n), 32'd5);
        check("bkpt_pc", 32'(pc_q), 32'h05);
        check("bkpt_cause", 32'(b1.stop_cause), 32'h3);
        check("bkpt_count", 32'(b1.cycle_count), 32'd5);
        b1.run_req = 0;
        tick();
        b1.run_req = 1;
        tick();
        check("resume_pc_en", 32'(b1.pc_en), 32'h1);
        check("resume_cause_clr", 32'(b1.stop_cause), 32'h0);
        tick();
        check("resume_pc", 32'(pc_q), 32'h06);
        check("resume_state", 32'(b1.state), 32'h2);
        tick();

        // Manual halt while running
        b1.halt_req = 1;
        #1;
        check("mhalt_pc_en", 32'(b1.pc_en), 32'h0);
        tick();
        check("mhalt_state", 32'(b1.state), 32'h1);
        check("mhalt_cause", 32'(b1.stop_cause), 32'h1);
        check("mhalt_pc", 32'(pc_q), 32'h07);
        check("mhalt_count", 32'(b1.cycle_count), 32'd7);
        b1.halt_req = 0;
        b1.run_req  = 0;
        tick();

        // Three single steps
        for (int k = 0; k < 3; k++) begin
            b1.step_req = 1;
            tick();
            check("step_state", 32'(b1.state), 32'h3);
            check("step_pc_en", 32'(b1.pc_en), 32'h1);
            tick();
            check("step_back_halt", 32'(b1.state), 32'h1);
            check("step_cause", 32'(b1.stop_cause), 32'h4);
            b1.step_req = 0;
            tick();
        end
        check("step_pc", 32'(pc_q), 32'h0A);
        check("step_count", 32'(b1.cycle_count), 32'd10);

        // Step and run edges together enter STEP
        b1.step_req = 1; b1.run_req = 1;
        tick();
        check("step_run_prio", 32'(b1.state), 32'h3);
        tick();
        b1.step_req = 0; b1.run_req = 0;
        tick();

        // Halt and step edges together stay in HALT
        b1.halt_req = 1; b1.step_req = 1;
        tick();
        check("halt_step_prio", 32'(b1.state), 32'h1);
        b1.halt_req = 0; b1.step_req = 0;
        tick();

        // run_req held through reset does not start a run
        b1.run_req = 1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("held_hold_state", 32'(b1.state), 32'h0);
        for (int i = 0; i < 6; i++) tick();
        check("held_no_run", 32'(b1.state), 32'h1);
        b1.run_req = 0;
        tick();
        b1.run_req = 1;
        tick();
        check("fresh_edge_run", 32'(b1.state), 32'h2);
        tick();
        tick();

        // Reset in the middle of a run
        reset = 1'b1;
        tick();
        check("midrun_state", 32'(b1.state), 32'h0);
        check("midrun_cpu_rst", 32'(b1.cpu_rst), 32'h1);
        check("midrun_count", 32'(b1.cycle_count), 32'h0);
        check("midrun_cause", 32'(b1.stop_cause), 32'h0);
        check("midrun_pc_en", 32'(b1.pc_en), 32'h0);
        reset = 1'b0;
        b1.run_req = 0;

        // Saturating counter on the CW=4 instance
        reset2 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("sat_halt", 32'(b2.state), 32'h1);
        b2.run_req = 1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("sat_reach", 32'(b2.cycle_count), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", 32'(b2.cycle_count), 32'd15);
        check("sat_running", 32'(b2.state), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/picomips_run_ctrl.md
Name: picomips_run_ctrl

Overview:
- Run/halt/single-step controller for the picoMIPS core.
- Holds the datapath in reset after power-up and gates the PC and architectural-state write enable (pc_en).
- Stops execution on a manual halt, a decoded HALT instruction, or a PC breakpoint.
- Sits between the board-level controls (buttons/switches) and the picoMIPS datapath, alongside the display path.

Parameters:
- PCW, 8, program counter width.
- CW, 16, executed-cycle counter width.
- HOLD, 4, cycles cpu_rst is held after reset deasserts (min 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run_req  in  1  run request, level; acts on its rising edge; synchronous to clk.
- halt_req  in  1  manual halt request, level; acts on its rising edge.
- step_req  in  1  single-step request, level; acts on its rising edge.
- bkpt_en  in  1  breakpoint enable.
- bkpt_addr  in  PCW  breakpoint address.
- pc  in  PCW  current PC from the datapath.
- halt_insn  in  1  decoder flag: the instruction at pc is HALT.
- cpu_rst  out  1  synchronous reset to the datapath.
- pc_en  out  1  PC/register-file/flag write enable (combinational).
- state  out  2  00 HOLD, 01 HALT, 10 RUN, 11 STEP.
- halted  out  1  high in the HALT state.
- stop_cause  out  3  000 none, 001 manual, 010 halt_insn, 011 bkpt, 100 step.
- cycle_count  out  CW  number of cycles with pc_en=1.

Behaviour:
- Reset values (reset high at an edge): state=HOLD, cpu_rst=1, pc_en=0, halted=0, stop_cause=000, cycle_count=0, hold counter=0.
- Edge-detect registers prev_run, prev_halt and prev_step reset to 1, so a button held through reset does not trigger.
- Edge detection: edge = input & ~prev, evaluated combinationally; prev updates every cycle.
- HOLD state:
  - cpu_rst=1; counts HOLD cycles after reset deasserts, then moves to HALT.
  - All request edges in HOLD are discarded.
- HALT state:
  - halted=1, pc_en=0.
  - Priority for simultaneous requests: halt edge (ignored, stays HALT) > step edge (go to STEP) > run edge (go to RUN).
  - Latency: an edge sampled at edge k means the new state is valid after edge k, so pc_en can be high in cycle k+1.
- RUN state:
  - stop_now = halt_insn | bkpt_hit | halt_edge.
  - bkpt_hit = bkpt_en & (pc == bkpt_addr) & ~first, where first is set on entry to RUN and clears after one cycle. This lets execution resume from a breakpoint address.
  - pc_en = ~stop_now; the stopping instruction is not executed.
  - When stop_now=1, go to HALT next cycle.
  - stop_cause priority: halt_insn (010) > bkpt (011) > manual (001).
- STEP state:
  - Lasts exactly one cycle; pc_en = ~halt_insn.
  - Next state HALT with stop_cause=100, or 010 if halt_insn.
  - Breakpoints are ignored in STEP.
- stop_cause: written only on entry to HALT; cleared to 000 on entry to RUN or STEP.
- HALT instruction: the PC stays on it. A later run edge gives one RUN cycle with pc_en=0, then HALT again with cause 010; this is intentional and sticky until reset.
- cycle_count: increments on every cycle with pc_en=1 and saturates at 2^CW-1; no wrap.
- reset asserted mid-RUN or mid-STEP: the next edge forces HOLD with cpu_rst=1 and all outputs returned to reset values.
- cpu_rst is low in every state except HOLD.

Test Plan:
- Reset for 1 cycle, HOLD=4: cpu_rst=1 for 4 cycles after release, then state=01, halted=1, pc_en=0, cycle_count=0.
- run_req rising with pc free-running from 0, bkpt_en=0, halt_insn raised when pc=0x0A: pc_en=1 for 10 cycles then 0; state=01, stop_cause=010, cycle_count=10.
- bkpt_en=1, bkpt_addr=0x05, run from pc=0: stops with pc=0x05 and stop_cause=011. A second run edge resumes: pc_en=1 in the first cycle (pc goes 0x05 to 0x06) and continues running.
- In HALT, step_req pulse three times: exactly 3 pc_en pulses, state returns to 01 each time with stop_cause=100, cycle_count += 3. Step and run edges in the same cycle: enters STEP.
- In RUN, halt_req rising: pc_en=0 in that cycle, stop_cause=001. run_req held high through reset: no RUN after HOLD until a fresh rising edge.
- In RUN, assert reset: state=00, cpu_rst=1, cycle_count=0 on the next edge. With CW=4, run 20 cycles: cycle_count saturates at 15.
